// File: rtl/adam_aes_encipher_engine.sv
// AES-128/192/256 encipher round engine with 1/2/4 S-box lanes and valid/ready block handshakes.
// Optional `abort` input enabled by defining ADAM_AES_ENC_ABORT_EN.
module adam_aes_encipher_engine #(
    parameter int SBOX_LANES = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                keylen,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              block,
    output logic [3:0]                round,
    input  logic [127:0]              round_key,
    output logic [32*SBOX_LANES-1:0]  sboxw,
    input  logic [32*SBOX_LANES-1:0]  new_sboxw,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              new_block,
    output logic                      busy
`ifdef ADAM_AES_ENC_ABORT_EN
    ,
    input  logic                      abort
`endif
);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : gen_bad_lanes
        $error("adam_aes_encipher_engine: SBOX_LANES must be 1, 2 or 4");
    end

    localparam int N  = 4 / SBOX_LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SBOX, MAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [127:0]    st_q;
    logic [CW-1:0]   ctr_q;
    logic [1:0]      kl_q;
    logic [3:0]      nr;
    logic            abort_req;
    int              word_base;

`ifdef ADAM_AES_ENC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the state lives at [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   b0, b1, b2, b3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            b0 = s[127-32*c -: 8];
            b1 = s[119-32*c -: 8];
            b2 = s[111-32*c -: 8];
            b3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
            o[119-32*c -: 8] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
            o[111-32*c -: 8] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
            o[103-32*c -: 8] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        end
        return o;
    endfunction

    always_comb begin
        case (kl_q)
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
    end

    // First state word handled by lane 0 in the current S-box cycle.
    assign word_base = (N == 1) ? 0 : int'(ctr_q) * SBOX_LANES;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort_req) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid) state_d = SBOX;
                SBOX:    if (ctr_q == CW'(N-1)) state_d = MAIN;
                MAIN:    state_d = (round == nr) ? DONE : SBOX;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sboxw     = '0;
        if (state_q == SBOX)
            for (int i = 0; i < SBOX_LANES; i++)
                sboxw[32*i +: 32] = st_q[127-32*(word_base+i) -: 32];
    end

    // The final round skips MixColumns and leaves round at NR for the consumer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q  <= '0;
            round <= '0;
            ctr_q <= '0;
            kl_q  <= 2'b00;
        end else if (abort_req) begin
            st_q  <= '0;
            round <= '0;
            ctr_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    st_q  <= block ^ round_key;
                    kl_q  <= keylen;
                    round <= 4'd1;
                    ctr_q <= '0;
                end
                SBOX: begin
                    for (int i = 0; i < SBOX_LANES; i++)
                        st_q[127-32*(word_base+i) -: 32] <= new_sboxw[32*i +: 32];
                    ctr_q <= ctr_q + CW'(1);
                end
                MAIN: if (round != nr) begin
                    st_q  <= mix_columns(shift_rows(st_q)) ^ round_key;
                    round <= round + 4'd1;
                    ctr_q <= '0;
                end else begin
                    st_q  <= shift_rows(st_q) ^ round_key;
                end
                DONE: if (out_ready) round <= '0;
                default: ;
            endcase
        end
    end

    assign new_block = st_q;

endmodule

// File: tb/tb_adam_aes_encipher_engine.sv
// Bench for adam_aes_encipher_engine: three instances (1/2/4 lanes) fed by a key-memory and S-box model,
// checked against FIPS-197 vectors. Abort checks compile in when ADAM_AES_ENC_ABORT_EN is defined.
module tb_adam_aes_encipher_engine;

    logic         clk;
    logic         reset_n;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   busy;
    logic [11:0]  rnd_all;
    logic [383:0] nb_all;
    logic [383:0] sw_all;
    logic [127:0] rkeys [15];
`ifdef ADAM_AES_ENC_ABORT_EN
    logic         abort;
`endif

    int compared;
    int mismatched;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [31:0] subWord(input logic [31:0] w);
        logic [31:0] o;
        for (int k = 0; k < 4; k++)
            o[8*k +: 8] = sbox_flat[2047 - 8*int'(w[8*k +: 8]) -: 8];
        return o;
    endfunction

    function automatic logic [7:0] xtime8(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int L = 1 << g;
        logic [32*L-1:0] sw, nsw;
        logic [127:0]    rk;
        logic [3:0]      r;
        assign r  = rnd_all[4*g +: 4];
        assign rk = (r > 4'd14) ? 128'd0 : rkeys[r];
        for (genvar i = 0; i < L; i++) begin : gen_lane
            assign nsw[32*i +: 32] = subWord(sw[32*i +: 32]);
        end
        assign sw_all[128*g +: 128] = 128'(sw);
        adam_aes_encipher_engine #(.SBOX_LANES(L)) dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .keylen    (keylen),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .block     (block),
            .round     (rnd_all[4*g +: 4]),
            .round_key (rk),
            .sboxw     (sw),
            .new_sboxw (nsw),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .new_block (nb_all[128*g +: 128]),
            .busy      (busy[g])
`ifdef ADAM_AES_ENC_ABORT_EN
            ,
            .abort     (abort)
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] nbOf(input int g);
        return nb_all[128*g +: 128];
    endfunction

    function automatic logic [3:0] rndOf(input int g);
        return rnd_all[4*g +: 4];
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Fills the key-memory model with the FIPS-197 key schedule.
    task automatic expandKey(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nrk;
        nk  = (kl == 2'b01) ? 6 : (kl == 2'b10) ? 8 : 4;
        nrk = nk + 6;
        rc  = 8'h01;
        for (int i = 0; i < 4*(nrk+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime8(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subWord(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 15; r++) begin
            if (r <= nrk) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else          rkeys[r] = '0;
        end
    endtask

    task automatic applyStimulus(input int g, input logic [1:0] kl, input logic [127:0] pt);
        keylen      = kl;
        block       = pt;
        in_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic waitResult(input int g, input int exp_lat, input logic [127:0] exp_ct,
                              input logic [3:0] exp_nr, input bit scramble);
        int cnt;
        cnt = 1;
        while (!out_valid[g] && cnt < 400) begin
            if (scramble) begin
                in_valid[g] = 1'($urandom_range(0, 1));
                block       = {$urandom, $urandom, $urandom, $urandom};
                keylen      = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            cnt++;
        end
        in_valid[g] = 1'b0;
        checkOutput("latency", 128'(cnt), 128'(exp_lat));
        checkOutput("ciphertext", nbOf(g), exp_ct);
        checkOutput("round_at_done", 128'(rndOf(g)), 128'(exp_nr));
        checkOutput("in_ready_done", 128'(in_ready[g]), 128'd0);
    endtask

    task automatic releaseResult(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[g] = 1'b0;
        checkOutput("out_valid_after_release", 128'(out_valid[g]), 128'd0);
        checkOutput("in_ready_after_release", 128'(in_ready[g]), 128'd1);
        checkOutput("round_after_release", 128'(rndOf(g)), 128'd0);
    endtask

    task automatic checkResetState(input int g);
        checkOutput("rst_in_ready", 128'(in_ready[g]), 128'd1);
        checkOutput("rst_out_valid", 128'(out_valid[g]), 128'd0);
        checkOutput("rst_busy", 128'(busy[g]), 128'd0);
        checkOutput("rst_round", 128'(rndOf(g)), 128'd0);
        checkOutput("rst_new_block", nbOf(g), 128'd0);
        checkOutput("rst_sboxw", sw_all[128*g +: 128], 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        keylen     = 2'b00;
        block      = '0;
        in_valid   = '0;
        out_ready  = '0;
`ifdef ADAM_AES_ENC_ABORT_EN
        abort      = 1'b0;
`endif
        expandKey(K128, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) checkResetState(g);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] AES-128 on every lane count");
        applyStimulus(0, 2'b00, PT); waitResult(0, 51, CT1, 4'd10, 1'b0); releaseResult(0);
        applyStimulus(1, 2'b00, PT); waitResult(1, 31, CT1, 4'd10, 1'b0); releaseResult(1);
        applyStimulus(2, 2'b00, PT); waitResult(2, 21, CT1, 4'd10, 1'b0); releaseResult(2);
        // Reserved keylen behaves as 128; accepted right after the previous release.
        applyStimulus(2, 2'b11, PT); waitResult(2, 21, CT1, 4'd10, 1'b0); releaseResult(2);

        $display("[TB] AES-192 and AES-256");
        expandKey(K192, 2'b01);
        applyStimulus(1, 2'b01, PT); waitResult(1, 37, CT2, 4'd12, 1'b0); releaseResult(1);
        expandKey(K256, 2'b10);
        applyStimulus(2, 2'b10, PT); waitResult(2, 29, CT3, 4'd14, 1'b0); releaseResult(2);
        applyStimulus(0, 2'b10, PT); waitResult(0, 71, CT3, 4'd14, 1'b0); releaseResult(0);

        $display("[TB] backpressure");
        expandKey(K128, 2'b00);
        applyStimulus(2, 2'b00, PT); waitResult(2, 21, CT1, 4'd10, 1'b0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (nbOf(2) !== CT1 || rndOf(2) !== 4'd10 || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1)
                bad++;
        end
        checkOutput("backpressure_hold", 128'(bad), 128'd0);
        releaseResult(2);

        $display("[TB] input activity while busy");
        applyStimulus(0, 2'b00, PT); waitResult(0, 51, CT1, 4'd10, 1'b1); releaseResult(0);

        $display("[TB] reset mid-operation");
        expandKey(K192, 2'b01);
        applyStimulus(1, 2'b01, PT);
        repeat (24) @(posedge clk);
        #1;
        checkOutput("busy_before_reset", 128'(busy[1]), 128'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkResetState(1);
        reset_n = 1'b1;
        applyStimulus(1, 2'b01, PT); waitResult(1, 37, CT2, 4'd12, 1'b0); releaseResult(1);

`ifdef ADAM_AES_ENC_ABORT_EN
        $display("[TB] abort");
        expandKey(K128, 2'b00);
        applyStimulus(0, 2'b00, PT);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_busy", 128'(busy[0]), 128'd0);
        checkOutput("abort_new_block", nbOf(0), 128'd0);
        checkOutput("abort_round", 128'(rndOf(0)), 128'd0);
        applyStimulus(0, 2'b00, PT); waitResult(0, 51, CT1, 4'd10, 1'b0);
        abort        = 1'b1;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        @(posedge clk);
        #1;
        abort        = 1'b0;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        checkOutput("abort_done_out_valid", 128'(out_valid[0]), 128'd0);
        checkOutput("abort_done_no_accept", 128'(busy[0]), 128'd0);
        checkOutput("abort_done_new_block", nbOf(0), 128'd0);
        checkOutput("abort_done_round", 128'(rndOf(0)), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
